uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  8N1 UART transmitter. It is the return path paired with the board's uartRX receiver.
//  The CPU or other logic pushes bytes through a valid/ready handshake into a small FIFO.
//  The block serialises each byte on tx at BAUD, LSB first, framed by a start bit and a stop bit.
//  It sits in the clk domain next to the receiver and drives the board TX pin directly.
// PARAMETERS
//  CLK_FREQ    50_000_000  input clock frequency, Hz
//  BAUD        115_200     line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 434 at default)
//  FIFO_DEPTH  4           byte entries, power of two, >=2
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst_n     in   1  asynchronous, active-low reset
//  data      in   8  byte to send
//  valid     in   1  data is presented; a push happens when valid && ready at posedge clk
//  ready     out  1  FIFO not full
//  tx        out  1  serial line; idle high; registered output
//  busy      out  1  FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//   tx=1, ready=1, busy=0; FIFO is emptied; FSM goes to IDLE; baud and bit counters clear.
//   A frame that was in progress is abandoned, and no partial stop bit is produced.
//  FIFO:
//   push = valid && ready. ready = (count != FIFO_DEPTH), taken from registered count.
//   A full FIFO ignores valid; the byte is not stored and no error is raised.
//   Push and pop may occur in the same cycle; count is then unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE)
//   IDLE:  tx=1. If the FIFO is non-empty, pop into shift register, clear counters, go to START.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA:  tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//          bit_idx runs 0..7; after bit 7 go to STOP.
//   STOP:  tx=1 for CLKS_PER_BIT cycles. At the last cycle:
//          - FIFO non-empty: pop and go straight to START (no idle gap, back-to-back frames).
//          - otherwise: go to IDLE.
//  Baud counter: 0..CLKS_PER_BIT-1; the bit boundary is at count==CLKS_PER_BIT-1.
//  Latency: push at edge N into an empty FIFO with FSM in IDLE.
//   - The pop occurs at edge N+1.
//   - tx falls at edge N+2.
//   - A frame lasts exactly 10*CLKS_PER_BIT cycles.
//  tx changes only on clk edges, so it is glitch-free. data is sampled only at push; later
//  changes to data do not affect a queued byte.
//  busy rises the cycle after the first push. It falls after the last stop bit completes
//  with the FIFO empty.
//  Elaboration assertion: CLKS_PER_BIT >= 2.
// STRUCTURE
//  uart_pkg (shared with uartRX rework):
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t
//   - function clks_per_bit(clk_freq, baud)
//   - localparam FRAME_BITS = 10
//  One sub-module, sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
//   - ports: push, pop, wdata, rdata, full, empty, count
//   - rdata is valid combinationally at the head while !empty
//  Top-level holds the FSM, baud counter, bit index and shift register.
// TESTING (sim params CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit)
//  1. Reset then idle 50 cycles -> tx=1, ready=1, busy=0 throughout.
//  2. Push 0x55 -> tx low from edge N+2 for 10 clk. The line then carries 1,0,1,0,1,0,1,0
//     (10 clk each), then stop=1. Total 100 clk. busy falls after.
//  3. Push 0x44, 0x4C, 0x52 on consecutive cycles -> three frames, each 100 clk, with no
//     idle gap between stop and next start. A model UART RX recovers 44,4C,52 in order.
//  4. Hold valid for 8 cycles with distinct bytes, FIFO_DEPTH=4 -> ready drops once 4 are
//     stored. Further bytes are not accepted. Exactly the accepted bytes appear on tx.
//  5. Pop frees a slot while valid is held -> push accepted the cycle ready returns high.
//     No byte is lost or duplicated.
//  6. Assert rst_n low in the middle of the DATA bit 3 of 0xA5 -> tx=1 immediately,
//     FIFO empty, busy=0. After release, push 0x3C -> one clean 0x3C frame only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

    // Clock cycles per serial bit (integer divide, truncating).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake into the UART transmitter: producer drives data/valid, UART answers ready.
interface uart_tx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head entry is visible on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Overflow and underflow requests are dropped here as well as at the caller.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array; cleared on reset so no stale byte is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte FIFO in front; frames are sent back-to-back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_fifo_if.slave     bus,
    output logic              tx,
    output logic              busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int FCW          = $clog2(FIFO_DEPTH) + 1;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             push_s;
    logic             pop_s;
    logic             baud_last_s;
    logic [7:0]       fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [FCW-1:0]   fifo_count_s;

    assign push_s      = bus.valid && bus.ready;
    assign bus.ready   = !fifo_full_s;
    assign baud_last_s = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign busy        = (state_q != IDLE) || (fifo_count_s != {FCW{1'b0}});
    assign tx          = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pop is issued whenever a new frame is launched.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_last_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_last_s && (bit_q == 3'd7)) begin
                    state_d = STOP;
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (baud_last_s && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = START;
                end else if (baud_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Baud counter, bit index and shift register next values.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        if ((state_q == IDLE) || baud_last_s) begin
            baud_d = {CNT_W{1'b0}};
        end else begin
            baud_d = baud_q + CNT_W'(1);
        end
        if (state_q != DATA) begin
            bit_d = 3'd0;
        end else if (baud_last_s) begin
            bit_d = bit_q + 3'd1;
        end else begin
            bit_d = bit_q;
        end
        if (pop_s) begin
            shift_d = fifo_rdata_s;
        end else if ((state_q == DATA) && baud_last_s) begin
            shift_d = {1'b0, shift_q[7:1]};
        end else begin
            shift_d = shift_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Line level for the current state; registered below so tx lags the state by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Registered serial output, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 1'b1;
        end else begin
            tx_q <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst_n;
    logic tx;
    logic busy;

    uart_tx_fifo_if bus_if();

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          frames_done = 0;
    logic [7:0]  exp_q[$];
    int          starts_q[$];
    logic        samp [FRAME];
    int          mon_cnt = 0;
    bit          mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level at sample i of a frame carrying byte b.
    function automatic logic line_level(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog cycle budget exceeded");
            $fatal(1, "watchdog");
        end
    end

    // Scoreboard capture: every completed handshake queues the byte it carried.
    always @(posedge clk) begin
        if (rst_n && bus_if.valid && bus_if.ready) begin
            exp_q.push_back(bus_if.data);
            accepted++;
        end
    end

    // Monitor: model receiver collects a full frame after each falling edge of tx.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                samp[0]    = tx;
                mon_cnt    = 1;
                starts_q.push_back(cyc);
            end
        end else begin
            samp[mon_cnt] = tx;
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                logic [7:0] dec;
                logic [7:0] want;
                int         bad;
                mon_active = 1'b0;
                frames_done++;
                for (int k = 1; k <= 8; k++) dec[k-1] = samp[CPB*k + CPB/2];
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, dec}, 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    check("frame_byte", {24'd0, dec}, {24'd0, want});
                    bad = 0;
                    for (int i = 0; i < FRAME; i++) begin
                        if (samp[i] !== line_level(want, i)) bad++;
                    end
                    check("frame_shape_bad_samples", bad, 0);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        bus_if.data  = b;
        bus_if.valid = 1'b1;
        for (t = 0; t < 2000; t++) begin
            if (bus_if.ready) break;
            @(negedge clk);
        end
        check("push_wait_ready", (t < 2000), 1);
        @(posedge clk);
        #1;
        bus_if.valid = 1'b0;
        bus_if.data  = ~b;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_active && !busy) break;
        end
        check("drain_done", (t < 3000), 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int acc0;
        int fr0;
        rst_n        = 1'b0;
        bus_if.data  = 8'h00;
        bus_if.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", bus_if.ready, 1);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        // 1: idle line
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", tx, 1);
            check("idle_ready", bus_if.ready, 1);
            check("idle_busy", busy, 0);
        end

        // 2: single 0x55 with exact latency and busy boundaries
        @(negedge clk);
        bus_if.data  = 8'h55;
        bus_if.valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.valid = 1'b0;
        bus_if.data  = 8'hAA;
        check("lat_busy_after_push", busy, 1);
        check("lat_tx_edge_n", tx, 1);
        @(posedge clk); #1;
        check("lat_tx_edge_n1", tx, 1);
        @(posedge clk); #1;
        check("lat_tx_edge_n2", tx, 0);
        repeat (98) @(posedge clk);
        #1;
        check("busy_last_stop_cycle", busy, 1);
        @(posedge clk); #1;
        check("busy_after_frame", busy, 0);
        drain();

        // 3: three back-to-back frames with no idle gap
        starts_q.delete();
        push_byte(8'h44);
        push_byte(8'h4C);
        push_byte(8'h52);
        drain();
        check("b2b_frame_count", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            check("b2b_gap_1", starts_q[1] - starts_q[0], FRAME);
            check("b2b_gap_2", starts_q[2] - starts_q[1], FRAME);
        end

        // 4: hold valid 8 cycles; one byte leaves immediately, then 4 fill the FIFO
        acc0 = accepted;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_if.data  = 8'h10 + 8'(i);
            bus_if.valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_if.valid = 1'b0;
        check("full_accepted", accepted - acc0, 5);
        check("full_ready_low", bus_if.ready, 0);

        // 5: byte held until a pop frees a slot
        push_byte(8'h99);
        check("refill_accepted", accepted - acc0, 6);
        drain();

        // Randomised traffic
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 120)) @(negedge clk);
            push_byte(8'($urandom));
        end
        drain();

        // 6: reset in the middle of data bit 3 of 0xA5
        fr0 = frames_done;
        @(negedge clk);
        bus_if.data  = 8'hA5;
        bus_if.valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.valid = 1'b0;
        repeat (47) @(posedge clk);
        @(negedge clk);
        check("pre_reset_bit3", tx, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_ready", bus_if.ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_no_frame", frames_done - fr0, 0);
        check("post_reset_tx", tx, 1);
        push_byte(8'h3C);
        drain();
        repeat (150) @(negedge clk);
        check("post_reset_one_frame", frames_done - fr0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
